// File: rtl/ext_bus_bridge_pkg.sv
// Shared constants for the external bus bridge: size codes, beat counts,
// FSM state encoding and the beat address / byte strobe helpers.
package ext_bus_bridge_pkg;

    // Size codes (bytes minus one) that select multi-beat bursts
    localparam logic [4:0] SZ_32B = 5'd31;
    localparam logic [4:0] SZ_16B = 5'd15;

    // Beat counts
    localparam logic [2:0] NB_1 = 3'd1;
    localparam logic [2:0] NB_2 = 3'd2;
    localparam logic [2:0] NB_4 = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WCAP = 3'd1,
        ST_WISS = 3'd2,
        ST_RISS = 3'd3,
        ST_ERR  = 3'd4
    } bridge_state_e;

    // Number of 64-bit beats for a request size; odd sizes collapse to one beat
    function automatic logic [2:0] beat_count(input logic [4:0] sz);
        logic [2:0] nb;
        case (sz)
            SZ_32B:  nb = NB_4;
            SZ_16B:  nb = NB_2;
            default: nb = NB_1;
        endcase
        return nb;
    endfunction

    // Doubleword address of beat k: 4-beat bursts wrap inside the 32-byte
    // line, 2-beat bursts toggle within the 16-byte half (critical word first)
    function automatic logic [28:0] beat_addr(input logic [28:0] base,
                                              input logic [2:0]  nb,
                                              input logic [1:0]  k);
        logic [28:0] a;
        case (nb)
            NB_4:    a = {base[28:2], base[1:0] + k};
            NB_2:    a = {base[28:1], base[0] ^ k[0]};
            default: a = base;
        endcase
        return a;
    endfunction

    // Byte strobes, big-endian lanes (byte 0 drives bit 7); single-beat
    // accesses are clipped at the end of the doubleword
    function automatic logic [7:0] byte_strobe(input logic [2:0] lo,
                                               input logic [4:0] sz,
                                               input logic [2:0] nb);
        logic [7:0] s;
        logic [5:0] hi;
        s  = 8'h00;
        hi = {3'b000, lo} + {1'b0, sz};
        if (nb != NB_1) begin
            s = 8'hFF;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if ((6'(i) >= {3'b000, lo}) && (6'(i) <= hi)) begin
                    s[3'(7 - i)] = 1'b1;
                end
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/ext_wbuf.sv
// Four-entry, 64-bit write beat buffer with one write port and one
// combinational read port.
module ext_wbuf
    import ext_bus_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [1:0]  widx,
    input  logic [63:0] wdata,
    input  logic [1:0]  ridx,
    output logic [63:0] rdata
);

    logic [63:0] buf_q [4];
    logic [63:0] buf_d [4];

    // Next buffer contents: write the addressed entry when enabled
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            buf_d[i] = buf_q[i];
        end
        if (we) begin
            buf_d[widx] = wdata;
        end else begin
            buf_d[widx] = buf_q[widx];
        end
    end

    // Buffer storage; reset discards any captured beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= 64'h0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign rdata = buf_q[ridx];

endmodule

// File: rtl/ext_bus_bridge.sv
// Bridge between the cache request interface and a beat-oriented memory
// port. Splits cache lines into 64-bit beats, buffers write data, returns
// read beats in order and reports memory errors or timeouts.
module ext_bus_bridge
    import ext_bus_bridge_pkg::*;
#(
    parameter int TMO_CYC = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        phi2,
    input  logic        extreq,
    input  logic        extwr,
    input  logic [4:0]  extsz,
    input  logic [31:0] extaddr,
    input  logic        extsrc,
    input  logic [63:0] extwdata,
    output logic        extrdy,
    output logic        extreply,
    output logic        extreplyto,
    output logic [63:0] extrdata,
    output logic        exterror,
    output logic        mem_req,
    output logic        mem_we,
    output logic [28:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err
);

    localparam int          TW       = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    bridge_state_e state_q, state_d;
    logic [28:0]   base_q, base_d;
    logic [2:0]    nb_q, nb_d;
    logic          src_q, src_d;
    logic [1:0]    iss_q, iss_d;
    logic [1:0]    cap_q, cap_d;
    logic [1:0]    rep_q, rep_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          extrdy_q, extrdy_d;
    logic          extreply_q, extreply_d;
    logic          extreplyto_q, extreplyto_d;
    logic [63:0]   extrdata_q, extrdata_d;
    logic          exterror_q, exterror_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [28:0]   mem_addr_q, mem_addr_d;
    logic [63:0]   mem_wdata_q, mem_wdata_d;
    logic [7:0]    mem_wstrb_q, mem_wstrb_d;

    logic          wb_we_s;
    logic [1:0]    wb_widx_s;
    logic [1:0]    wb_ridx_s;
    logic [63:0]   wb_rdata_s;
    logic [2:0]    acc_nb_s;
    logic          gnt_s, rv_s, prog_s, tmo_hit_s, err_s;
    logic          last_iss_s, last_rep_s, last_cap_s;

    ext_wbuf u_wbuf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wb_we_s & phi2),
        .widx    (wb_widx_s),
        .wdata   (extwdata),
        .ridx    (wb_ridx_s),
        .rdata   (wb_rdata_s)
    );

    // Event decode: qualified grant/return, progress, timeout and error
    always_comb begin
        acc_nb_s   = beat_count(extsz);
        gnt_s      = mem_req_q & mem_gnt;
        rv_s       = (state_q == ST_RISS) & mem_rvalid;
        prog_s     = gnt_s | rv_s;
        tmo_hit_s  = ((state_q == ST_WISS) | (state_q == ST_RISS)) & ~prog_s
                     & (tmo_q == TMO_LAST);
        err_s      = (gnt_s & mem_err) | (rv_s & mem_err) | tmo_hit_s;
        last_iss_s = ({1'b0, iss_q} == (nb_q - 3'd1));
        last_rep_s = ({1'b0, rep_q} == (nb_q - 3'd1));
        last_cap_s = ({1'b0, cap_q} == (nb_q - 3'd1));
        // The next write beat is read out ahead of its grant
        wb_ridx_s  = (state_q == ST_WISS) ? (iss_q + 2'd1) : 2'd0;
    end

    // Next-state and next-output computation for the transfer FSM
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        nb_d         = nb_q;
        src_d        = src_q;
        iss_d        = iss_q;
        cap_d        = cap_q;
        rep_d        = rep_q;
        tmo_d        = tmo_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        extreply_d   = 1'b0;
        exterror_d   = 1'b0;
        extreplyto_d = extreplyto_q;
        extrdata_d   = extrdata_q;
        wb_we_s      = 1'b0;
        wb_widx_s    = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (extreq) begin
                    base_d      = extaddr[31:3];
                    nb_d        = acc_nb_s;
                    src_d       = extsrc;
                    iss_d       = 2'd0;
                    rep_d       = 2'd0;
                    cap_d       = 2'd1;
                    tmo_d       = '0;
                    mem_addr_d  = extaddr[31:3];
                    mem_wstrb_d = byte_strobe(extaddr[2:0], extsz, acc_nb_s);
                    if (extwr) begin
                        wb_we_s   = 1'b1;
                        wb_widx_s = 2'd0;
                        if (acc_nb_s == NB_1) begin
                            state_d     = ST_WISS;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = extwdata;
                        end else begin
                            state_d = ST_WCAP;
                        end
                    end else begin
                        state_d   = ST_RISS;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WCAP: begin
                wb_we_s   = 1'b1;
                wb_widx_s = cap_q;
                if (last_cap_s) begin
                    state_d     = ST_WISS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = wb_rdata_s;
                end else begin
                    cap_d = cap_q + 2'd1;
                end
            end

            ST_WISS: begin
                if (err_s) begin
                    state_d      = ST_ERR;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    extreply_d   = 1'b1;
                    exterror_d   = 1'b1;
                    extreplyto_d = src_q;
                    tmo_d        = '0;
                end else if (gnt_s) begin
                    tmo_d = '0;
                    if (last_iss_s) begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                    end else begin
                        iss_d       = iss_q + 2'd1;
                        mem_addr_d  = beat_addr(base_q, nb_q, iss_q + 2'd1);
                        mem_wdata_d = wb_rdata_s;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_RISS: begin
                if (err_s) begin
                    state_d      = ST_ERR;
                    mem_req_d    = 1'b0;
                    extreply_d   = 1'b1;
                    exterror_d   = 1'b1;
                    extreplyto_d = src_q;
                    tmo_d        = '0;
                end else begin
                    tmo_d = prog_s ? '0 : (tmo_q + TW'(1));
                    if (gnt_s) begin
                        if (last_iss_s) begin
                            mem_req_d = 1'b0;
                        end else begin
                            iss_d      = iss_q + 2'd1;
                            mem_addr_d = beat_addr(base_q, nb_q, iss_q + 2'd1);
                        end
                    end else begin
                        iss_d = iss_q;
                    end
                    if (rv_s) begin
                        extreply_d   = 1'b1;
                        extrdata_d   = mem_rdata;
                        extreplyto_d = src_q;
                        if (last_rep_s) begin
                            state_d   = ST_IDLE;
                            mem_req_d = 1'b0;
                        end else begin
                            rep_d = rep_q + 2'd1;
                        end
                    end else begin
                        rep_d = rep_q;
                    end
                end
            end

            ST_ERR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        extrdy_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; advance only on phi2 cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            base_q       <= 29'h0;
            nb_q         <= NB_1;
            src_q        <= 1'b0;
            iss_q        <= 2'd0;
            cap_q        <= 2'd0;
            rep_q        <= 2'd0;
            tmo_q        <= '0;
            extrdy_q     <= 1'b1;
            extreply_q   <= 1'b0;
            extreplyto_q <= 1'b0;
            extrdata_q   <= 64'h0;
            exterror_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 29'h0;
            mem_wdata_q  <= 64'h0;
            mem_wstrb_q  <= 8'h00;
        end else if (phi2) begin
            state_q      <= state_d;
            base_q       <= base_d;
            nb_q         <= nb_d;
            src_q        <= src_d;
            iss_q        <= iss_d;
            cap_q        <= cap_d;
            rep_q        <= rep_d;
            tmo_q        <= tmo_d;
            extrdy_q     <= extrdy_d;
            extreply_q   <= extreply_d;
            extreplyto_q <= extreplyto_d;
            extrdata_q   <= extrdata_d;
            exterror_q   <= exterror_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
        end
    end

    assign extrdy     = extrdy_q;
    assign extreply   = extreply_q;
    assign extreplyto = extreplyto_q;
    assign extrdata   = extrdata_q;
    assign exterror   = exterror_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Directed testbench for ext_bus_bridge: reads of each burst length,
// writes with stalls, strobe clipping, errors, timeout and mid-burst reset.
module tb_ext_bus_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        phi2;
    logic        extreq;
    logic        extwr;
    logic [4:0]  extsz;
    logic [31:0] extaddr;
    logic        extsrc;
    logic [63:0] extwdata;
    logic        extrdy;
    logic        extreply;
    logic        extreplyto;
    logic [63:0] extrdata;
    logic        exterror;
    logic        mem_req;
    logic        mem_we;
    logic [28:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_err;

    int n_checks = 0;
    int n_pass   = 0;

    ext_bus_bridge #(.TMO_CYC(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .phi2       (phi2),
        .extreq     (extreq),
        .extwr      (extwr),
        .extsz      (extsz),
        .extaddr    (extaddr),
        .extsrc     (extsrc),
        .extwdata   (extwdata),
        .extrdy     (extrdy),
        .extreply   (extreply),
        .extreplyto (extreplyto),
        .extrdata   (extrdata),
        .exterror   (exterror),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    // Memory contents seen by reads: a tag plus the doubleword address
    function automatic logic [63:0] data_of(input logic [28:0] a);
        return {16'hC0DE, 19'h0, a};
    endfunction

    task automatic test_reset();
        #3;
        n_checks++; if (extreply !== 1'b0) $display("FAIL rst_extreply: got %b want 0", extreply); else n_pass++;
        n_checks++; if (exterror !== 1'b0) $display("FAIL rst_exterror: got %b want 0", exterror); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else n_pass++;
        n_checks++; if (mem_wstrb !== 8'h00) $display("FAIL rst_wstrb: got %h want 00", mem_wstrb); else n_pass++;
        n_checks++; if (mem_addr !== 29'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (extrdata !== 64'h0) $display("FAIL rst_extrdata: got %h want 0", extrdata); else n_pass++;
        n_checks++; if (extreplyto !== 1'b0) $display("FAIL rst_replyto: got %b want 0", extreplyto); else n_pass++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (extrdy !== 1'b1) $display("FAIL rst_extrdy: got %b want 1", extrdy); else n_pass++;
    endtask

    task automatic test_phi2_hold();
        phi2 = 1'b0; extreq = 1'b1; extwr = 1'b0; extsz = 5'd0; extaddr = 32'h80;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL phi2_mem_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (extrdy !== 1'b1) $display("FAIL phi2_extrdy: got %b want 1", extrdy); else n_pass++;
        extreq = 1'b0; phi2 = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read(input logic [4:0] sz, input logic [31:0] addr, input logic src,
                             input logic [28:0] a0, input logic [28:0] a1,
                             input logic [28:0] a2, input logic [28:0] a3,
                             input int n, input string nm);
        logic [28:0] exp_a [4];
        logic [28:0] gq [$];
        logic [63:0] last_d;
        logic        will_g;
        logic [28:0] will_a;
        int          reps;
        exp_a = '{a0, a1, a2, a3};
        reps = 0; last_d = 64'h0;
        extreq = 1'b1; extwr = 1'b0; extsz = sz; extaddr = addr; extsrc = src;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_err = 1'b0;
        @(posedge clk); #1;
        extreq = 1'b0;
        will_g = mem_req & mem_gnt; will_a = mem_addr;
        for (int c = 0; c < 30 && reps < n; c++) begin
            @(posedge clk); #1;
            if (extreply === 1'b1) begin
                n_checks++;
                if (extrdata !== data_of(exp_a[reps])) $display("FAIL %s data[%0d]: got %h want %h", nm, reps, extrdata, data_of(exp_a[reps]));
                else n_pass++;
                n_checks++;
                if (extreplyto !== src) $display("FAIL %s replyto[%0d]: got %b want %b", nm, reps, extreplyto, src);
                else n_pass++;
                n_checks++;
                if (exterror !== 1'b0) $display("FAIL %s exterror[%0d]: got %b want 0", nm, reps, exterror);
                else n_pass++;
                last_d = data_of(exp_a[reps]);
                reps++;
            end
            mem_rvalid = will_g;
            if (will_g) begin
                gq.push_back(will_a);
                mem_rdata = data_of(will_a);
            end
            will_g = mem_req & mem_gnt; will_a = mem_addr;
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        n_checks++; if (reps != n) $display("FAIL %s replies: got %0d want %0d", nm, reps, n); else n_pass++;
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (k >= gq.size()) $display("FAIL %s addr[%0d]: got none want %h", nm, k, exp_a[k]);
            else if (gq[k] !== exp_a[k]) $display("FAIL %s addr[%0d]: got %h want %h", nm, k, gq[k], exp_a[k]);
            else n_pass++;
        end
        @(posedge clk); #1;
        n_checks++; if (extrdy !== 1'b1) $display("FAIL %s extrdy_after: got %b want 1", nm, extrdy); else n_pass++;
        n_checks++; if (extreply !== 1'b0) $display("FAIL %s extreply_after: got %b want 0", nm, extreply); else n_pass++;
        n_checks++; if (extrdata !== last_d) $display("FAIL %s extrdata_hold: got %h want %h", nm, extrdata, last_d); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL %s mem_req_after: got %b want 0", nm, mem_req); else n_pass++;
    endtask

    task automatic test_write(input logic [4:0] sz, input logic [31:0] addr,
                              input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [63:0] d3,
                              input int n, input int dly, input logic [7:0] strb,
                              input logic [28:0] a0, input logic [28:0] a1,
                              input logic [28:0] a2, input logic [28:0] a3,
                              input string nm);
        logic [63:0] dd [4];
        logic [28:0] aa [4];
        int fed, g, wt, bad_rdy, bad_rep;
        dd = '{d0, d1, d2, d3}; aa = '{a0, a1, a2, a3};
        fed = 1; g = 0; wt = 0; bad_rdy = 0; bad_rep = 0;
        extreq = 1'b1; extwr = 1'b1; extsz = sz; extaddr = addr; extwdata = dd[0];
        mem_gnt = 1'b0; mem_err = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        extreq = 1'b0;
        for (int c = 0; c < 60 && g < n; c++) begin
            if (fed < n) begin extwdata = dd[fed]; fed++; end
            if (extrdy !== 1'b0) bad_rdy++;
            if (extreply !== 1'b0) bad_rep++;
            if (mem_req === 1'b1 && mem_we === 1'b1) begin
                if (wt == dly) begin
                    n_checks++; if (mem_addr !== aa[g]) $display("FAIL %s addr[%0d]: got %h want %h", nm, g, mem_addr, aa[g]); else n_pass++;
                    n_checks++; if (mem_wdata !== dd[g]) $display("FAIL %s wdata[%0d]: got %h want %h", nm, g, mem_wdata, dd[g]); else n_pass++;
                    n_checks++; if (mem_wstrb !== strb) $display("FAIL %s wstrb[%0d]: got %h want %h", nm, g, mem_wstrb, strb); else n_pass++;
                    mem_gnt = 1'b1; g++; wt = 0;
                end else begin
                    mem_gnt = 1'b0; wt++;
                end
            end else begin
                mem_gnt = 1'b0;
            end
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0;
        n_checks++; if (g != n) $display("FAIL %s beats: got %0d want %0d", nm, g, n); else n_pass++;
        n_checks++; if (bad_rdy != 0) $display("FAIL %s extrdy_busy: got %0d cycles high want 0", nm, bad_rdy); else n_pass++;
        n_checks++; if (bad_rep != 0 || extreply !== 1'b0) $display("FAIL %s extreply: got %0d want 0", nm, bad_rep); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL %s mem_req_after: got %b want 0", nm, mem_req); else n_pass++;
        n_checks++; if (extrdy !== 1'b1) $display("FAIL %s extrdy_after: got %b want 1", nm, extrdy); else n_pass++;
    endtask

    task automatic test_timeout();
        int at;
        at = 0;
        extreq = 1'b1; extwr = 1'b0; extsz = 5'd0; extaddr = 32'h40; extsrc = 1'b1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
        @(posedge clk); #1;
        extreq = 1'b0;
        for (int c = 1; c <= 10 && at == 0; c++) begin
            @(posedge clk); #1;
            if (extreply === 1'b1) at = c;
        end
        n_checks++; if (at != 4) $display("FAIL tmo_cycles: got %0d want 4", at); else n_pass++;
        n_checks++; if (exterror !== 1'b1) $display("FAIL tmo_exterror: got %b want 1", exterror); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL tmo_mem_req: got %b want 0", mem_req); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (extreply !== 1'b0 || exterror !== 1'b0) $display("FAIL tmo_pulse: got %b%b want 00", extreply, exterror); else n_pass++;
        n_checks++; if (extrdy !== 1'b1) $display("FAIL tmo_extrdy: got %b want 1", extrdy); else n_pass++;
    endtask

    task automatic test_write_err();
        extreq = 1'b1; extwr = 1'b1; extsz = 5'd0; extaddr = 32'h8; extwdata = 64'h1122334455667788;
        mem_gnt = 1'b1; mem_err = 1'b1; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        extreq = 1'b0;
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_err = 1'b0;
        n_checks++; if (extreply !== 1'b1 || exterror !== 1'b1) $display("FAIL werr_reply: got %b%b want 11", extreply, exterror); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL werr_mem_req: got %b want 0", mem_req); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (extreply !== 1'b0 || extrdy !== 1'b1) $display("FAIL werr_idle: got reply %b rdy %b want 0 1", extreply, extrdy); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic        will_g;
        logic [28:0] will_a;
        int reps, late_rep, late_req;
        reps = 0; late_rep = 0; late_req = 0;
        extreq = 1'b1; extwr = 1'b0; extsz = 5'd31; extaddr = 32'h200; extsrc = 1'b0;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_err = 1'b0;
        @(posedge clk); #1;
        extreq = 1'b0;
        will_g = mem_req & mem_gnt; will_a = mem_addr;
        for (int c = 0; c < 20 && reps < 2; c++) begin
            @(posedge clk); #1;
            if (extreply === 1'b1) reps++;
            mem_rvalid = will_g;
            mem_rdata = data_of(will_a);
            will_g = mem_req & mem_gnt; will_a = mem_addr;
        end
        n_checks++; if (reps != 2) $display("FAIL mrst_pre_replies: got %0d want 2", reps); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0 || extreply !== 1'b0) $display("FAIL mrst_async: got req %b reply %b want 0 0", mem_req, extreply); else n_pass++;
        mem_rvalid = 1'b1; mem_gnt = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (extreply !== 1'b0) late_rep++;
            if (mem_req !== 1'b0) late_req++;
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        n_checks++; if (late_rep != 0) $display("FAIL mrst_late_reply: got %0d want 0", late_rep); else n_pass++;
        n_checks++; if (late_req != 0) $display("FAIL mrst_mem_req: got %0d want 0", late_req); else n_pass++;
        n_checks++; if (extrdy !== 1'b1) $display("FAIL mrst_extrdy: got %b want 1", extrdy); else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0; phi2 = 1'b1; extreq = 1'b0; extwr = 1'b0; extsz = 5'd0;
        extaddr = 32'h0; extsrc = 1'b0; extwdata = 64'h0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 64'h0; mem_err = 1'b0;
        test_reset();
        test_phi2_hold();
        test_read(5'd31, 32'h100, 1'b1, 29'h20, 29'h21, 29'h22, 29'h23, 4, "rd4");
        test_read(5'd15, 32'h108, 1'b0, 29'h21, 29'h20, 29'h0, 29'h0, 2, "rd2");
        test_read(5'd7, 32'h238, 1'b1, 29'h47, 29'h0, 29'h0, 29'h0, 1, "rd1");
        test_write(5'd3, 32'h104, 64'hDEADBEEFCAFEBABE, 64'h0, 64'h0, 64'h0,
                   1, 0, 8'h0F, 29'h20, 29'h0, 29'h0, 29'h0, "wr1");
        test_write(5'd5, 32'h6, 64'h0123456789ABCDEF, 64'h0, 64'h0, 64'h0,
                   1, 1, 8'h03, 29'h0, 29'h0, 29'h0, 29'h0, "wrclip");
        test_write(5'd31, 32'h1F0, 64'hA0A0A0A0A0A0A0A0, 64'hB1B1B1B1B1B1B1B1,
                   64'hC2C2C2C2C2C2C2C2, 64'hD3D3D3D3D3D3D3D3,
                   4, 3, 8'hFF, 29'h3E, 29'h3F, 29'h3C, 29'h3D, "wr4");
        test_timeout();
        test_write_err();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
